// File: rtl/pipe_stage_skid_if.sv
`default_nettype none
// ============================================================================
// Module : pipe_stage_skid_if -- valid/ready stream carrying ctrl + payload
// Rev    : 1.0
// ============================================================================
interface pipe_stage_skid_if #(
  parameter int CTRL_W = 22,
  parameter int DATA_W = 128
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input  ready);
  modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module : pipe_stage_skid -- elastic pipeline register, optional 2-entry skid
// Rev    : 1.0
// ============================================================================
module pipe_stage_skid #(
  parameter int CTRL_W = 22,
  parameter int DATA_W = 128,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  wire              clk,
  input  wire              reset,
  input  wire              flush_i,
  pipe_stage_skid_if.slave  up,
  pipe_stage_skid_if.master dn,
  output logic [1:0]       occupancy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic              m_valid_q, m_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic [CNT_W-1:0]  stall_q,   stall_d;

  logic accept;
  logic consume;

  assign accept  = up.valid & up.ready;
  assign consume = m_valid_q & dn.ready;

  assign dn.valid    = m_valid_q;
  assign dn.ctrl     = m_ctrl_q;
  assign dn.data     = m_data_q;
  assign stall_cnt_o = stall_q;

  always_comb begin
    stall_d = stall_q;
    if (m_valid_q && !dn.ready && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_ctrl_q  <= '0;
      m_data_q  <= '0;
      stall_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_ctrl_q  <= m_ctrl_d;
      m_data_q  <= m_data_d;
      stall_q   <= stall_d;
    end
  end

  if (SKID != 0) begin : g_skid
    logic              s_valid_q, s_valid_d;
    logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
    logic [DATA_W-1:0] s_data_q,  s_data_d;

    // in_ready comes straight from a flop, so out_ready never reaches it
    assign up.ready    = ~s_valid_q;
    assign occupancy_o = {1'b0, m_valid_q} + {1'b0, s_valid_q};

    always_comb begin
      m_valid_d = m_valid_q;
      m_ctrl_d  = m_ctrl_q;
      m_data_d  = m_data_q;
      s_valid_d = s_valid_q;
      s_ctrl_d  = s_ctrl_q;
      s_data_d  = s_data_q;
      if (flush_i) begin
        m_valid_d = 1'b0;
        m_ctrl_d  = '0;
        s_valid_d = 1'b0;
        s_ctrl_d  = '0;
      end else if (consume) begin
        if (s_valid_q) begin
          m_valid_d = 1'b1;
          m_ctrl_d  = s_ctrl_q;
          m_data_d  = s_data_q;
          s_valid_d = 1'b0;
          s_ctrl_d  = '0;
        end else if (accept) begin
          m_valid_d = 1'b1;
          m_ctrl_d  = up.ctrl;
          m_data_d  = up.data;
        end else begin
          m_valid_d = 1'b0;
          m_ctrl_d  = '0;
        end
      end else if (accept) begin
        // M is either empty or stalled; a stalled M spills into S
        if (!m_valid_q) begin
          m_valid_d = 1'b1;
          m_ctrl_d  = up.ctrl;
          m_data_d  = up.data;
        end else begin
          s_valid_d = 1'b1;
          s_ctrl_d  = up.ctrl;
          s_data_d  = up.data;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        s_valid_q <= 1'b0;
        s_ctrl_q  <= '0;
        s_data_q  <= '0;
      end else begin
        s_valid_q <= s_valid_d;
        s_ctrl_q  <= s_ctrl_d;
        s_data_q  <= s_data_d;
      end
    end
  end else begin : g_noskid
    assign up.ready    = dn.ready | ~m_valid_q;
    assign occupancy_o = {1'b0, m_valid_q};

    always_comb begin
      m_valid_d = m_valid_q;
      m_ctrl_d  = m_ctrl_q;
      m_data_d  = m_data_q;
      if (flush_i) begin
        m_valid_d = 1'b0;
        m_ctrl_d  = '0;
      end else if (accept) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = up.ctrl;
        m_data_d  = up.data;
      end else if (consume) begin
        m_valid_d = 1'b0;
        m_ctrl_d  = '0;
      end
    end
  end

endmodule
`default_nettype wire
